// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: timing bundle between the VGA sync generator (master) and its consumer (slave)
interface vga_sync_gen_if;
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;
    modport master (input pix_en, output hsync, vsync, video_on, pix_x, pix_y, frame_start, frame_cnt);
    modport slave (output pix_en, input hsync, vsync, video_on, pix_x, pix_y, frame_start, frame_cnt);
`else
    modport master (input pix_en, output hsync, vsync, video_on, pix_x, pix_y, frame_start);
    modport slave (output pix_en, input hsync, vsync, video_on, pix_x, pix_y, frame_start);
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA pixel/line counters with sync, blanking and frame-start decode; VGA_FRAME_CNT_EN adds an 8-bit frame counter
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input logic            clk,
    input logic            rst,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
    logic       wrap_h;
    logic       wrap_f;

    assign wrap_h = vga.pix_en && x == H_LAST;
    assign wrap_f = wrap_h && y == V_LAST;

    // pixel/line counters advance on the pixel tick; frame_start flags the tick that wraps to (0,0)
    always_ff @(posedge clk) begin
        if (rst) begin
            x  <= '0;
            y  <= '0;
            fs <= 1'b0;
        end else begin
            fs <= wrap_f;
            if (vga.pix_en) x <= wrap_h ? '0 : x + 10'd1;
            if (wrap_h) y <= wrap_f ? '0 : y + 10'd1;
        end
    end

    assign vga.pix_x       = x;
    assign vga.pix_y       = y;
    assign vga.frame_start = fs;
    assign vga.hsync       = !(x >= HS_BEG && x < HS_END);
    assign vga.vsync       = !(y >= VS_BEG && y < VS_END);
    assign vga.video_on    = x < H_VIS && y < V_VIS;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] cnt;

    // frame counter steps on the same edge that raises frame_start
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (wrap_f) cnt <= cnt + 8'd1;
    end

    assign vga.frame_cnt = cnt;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen; default-timing DUT for line checks, small-timing DUT for frame checks
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic rst_d = 1'b1;
    logic rst_s = 1'b1;
    int   errors = 0;
    int   checks = 0;

    vga_sync_gen_if vd ();
    vga_sync_gen_if vs ();

    // small timing: H 8+2+3+2=15 (sync x 10..12), V 6+1+2+1=10 (sync y 7..8), frame 150 clks
    vga_sync_gen dut_d (.clk(clk), .rst(rst_d), .vga(vd));
    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_s (.clk(clk), .rst(rst_s), .vga(vs));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_d = 1'b1; rst_s = 1'b1; vd.pix_en = 1'b1; vs.pix_en = 1'b1;
        repeat (3) step();
        checks += 6;
        if (vd.pix_x !== 10'd0) begin errors++; $display("FAIL rst_pix_x got %0d exp 0", vd.pix_x); end
        if (vd.pix_y !== 10'd0) begin errors++; $display("FAIL rst_pix_y got %0d exp 0", vd.pix_y); end
        if (vd.hsync !== 1'b1) begin errors++; $display("FAIL rst_hsync got %b exp 1", vd.hsync); end
        if (vd.vsync !== 1'b1) begin errors++; $display("FAIL rst_vsync got %b exp 1", vd.vsync); end
        if (vd.video_on !== 1'b1) begin errors++; $display("FAIL rst_video_on got %b exp 1", vd.video_on); end
        if (vd.frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start got %b exp 0", vd.frame_start); end
    endtask

    task automatic test_hsync();
        logic [9:0] hs_fall, hs_rise, vo_fall, x799, y799;
        logic prev_hs, prev_vo;
        hs_fall = 10'h3ff; hs_rise = 10'h3ff; vo_fall = 10'h3ff; x799 = 10'h3ff; y799 = 10'h3ff;
        prev_hs = 1'b1; prev_vo = 1'b1;
        rst_d = 1'b0;
        for (int k = 1; k <= 800; k++) begin
            step();
            if (prev_hs && !vd.hsync && hs_fall == 10'h3ff) hs_fall = vd.pix_x;
            if (!prev_hs && vd.hsync && hs_rise == 10'h3ff) hs_rise = vd.pix_x;
            if (prev_vo && !vd.video_on && vo_fall == 10'h3ff) vo_fall = vd.pix_x;
            prev_hs = vd.hsync;
            prev_vo = vd.video_on;
            if (k == 799) begin x799 = vd.pix_x; y799 = vd.pix_y; end
        end
        checks += 7;
        if (hs_fall !== 10'd656) begin errors++; $display("FAIL hsync_fall_x got %0d exp 656", hs_fall); end
        if (hs_rise !== 10'd752) begin errors++; $display("FAIL hsync_rise_x got %0d exp 752", hs_rise); end
        if (vo_fall !== 10'd640) begin errors++; $display("FAIL video_on_fall_x got %0d exp 640", vo_fall); end
        if (x799 !== 10'd799) begin errors++; $display("FAIL last_pix_x got %0d exp 799", x799); end
        if (y799 !== 10'd0) begin errors++; $display("FAIL last_pix_y got %0d exp 0", y799); end
        if (vd.pix_x !== 10'd0) begin errors++; $display("FAIL wrap_pix_x got %0d exp 0", vd.pix_x); end
        if (vd.pix_y !== 10'd1) begin errors++; $display("FAIL wrap_pix_y got %0d exp 1", vd.pix_y); end
    endtask

    task automatic test_hold();
        repeat (3) step();
        vd.pix_en = 1'b0;
        repeat (4) step();
        checks += 2;
        if (vd.pix_x !== 10'd3) begin errors++; $display("FAIL hold_pix_x got %0d exp 3", vd.pix_x); end
        if (vd.pix_y !== 10'd1) begin errors++; $display("FAIL hold_pix_y got %0d exp 1", vd.pix_y); end
        vd.pix_en = 1'b1;
    endtask

    task automatic test_frame();
        int first_fs, fs_cnt, vs_low, vs_min, vs_max;
        logic [9:0] x150, y150;
        first_fs = -1; fs_cnt = 0; vs_low = 0; vs_min = 1023; vs_max = -1; x150 = 10'h3ff; y150 = 10'h3ff;
        rst_s = 1'b1; vs.pix_en = 1'b1;
        step();
        rst_s = 1'b0;
        for (int k = 1; k <= 151; k++) begin
            step();
            if (vs.frame_start === 1'b1) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = k;
            end
            if (k <= 150 && vs.vsync === 1'b0) begin
                vs_low++;
                if (int'(vs.pix_y) < vs_min) vs_min = int'(vs.pix_y);
                if (int'(vs.pix_y) > vs_max) vs_max = int'(vs.pix_y);
            end
            if (k == 150) begin x150 = vs.pix_x; y150 = vs.pix_y; end
        end
        checks += 7;
        if (first_fs != 150) begin errors++; $display("FAIL frame_start_cycle got %0d exp 150", first_fs); end
        if (fs_cnt != 1) begin errors++; $display("FAIL frame_start_width got %0d exp 1", fs_cnt); end
        if (vs_low != 30) begin errors++; $display("FAIL vsync_low_cycles got %0d exp 30", vs_low); end
        if (vs_min != 7) begin errors++; $display("FAIL vsync_first_line got %0d exp 7", vs_min); end
        if (vs_max != 8) begin errors++; $display("FAIL vsync_last_line got %0d exp 8", vs_max); end
        if (x150 !== 10'd0) begin errors++; $display("FAIL frame_wrap_x got %0d exp 0", x150); end
        if (y150 !== 10'd0) begin errors++; $display("FAIL frame_wrap_y got %0d exp 0", y150); end
    endtask

    task automatic test_divide();
        int first_fs, fs_cnt;
        logic [9:0] x10, x11;
        first_fs = -1; fs_cnt = 0; x10 = 10'h3ff; x11 = 10'h3ff;
        rst_s = 1'b1; vs.pix_en = 1'b1;
        step();
        rst_s = 1'b0;
        for (int k = 1; k <= 302; k++) begin
            vs.pix_en = (k % 2 == 0);
            step();
            if (vs.frame_start === 1'b1) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = k;
            end
            if (k == 10) x10 = vs.pix_x;
            if (k == 11) x11 = vs.pix_x;
        end
        vs.pix_en = 1'b1;
        checks += 4;
        if (x10 !== 10'd5) begin errors++; $display("FAIL div2_x_step10 got %0d exp 5", x10); end
        if (x11 !== 10'd5) begin errors++; $display("FAIL div2_x_step11 got %0d exp 5", x11); end
        if (first_fs != 300) begin errors++; $display("FAIL div2_frame_start_cycle got %0d exp 300", first_fs); end
        if (fs_cnt != 1) begin errors++; $display("FAIL div2_frame_start_width got %0d exp 1", fs_cnt); end
    endtask

    task automatic test_mid_reset();
        rst_s = 1'b1; vs.pix_en = 1'b1;
        step();
        rst_s = 1'b0;
        repeat (132) step();
        checks += 4;
        if (vs.pix_x !== 10'd12) begin errors++; $display("FAIL mid_pre_x got %0d exp 12", vs.pix_x); end
        if (vs.pix_y !== 10'd8) begin errors++; $display("FAIL mid_pre_y got %0d exp 8", vs.pix_y); end
        if (vs.vsync !== 1'b0) begin errors++; $display("FAIL mid_pre_vsync got %b exp 0", vs.vsync); end
        if (vs.hsync !== 1'b0) begin errors++; $display("FAIL mid_pre_hsync got %b exp 0", vs.hsync); end
        rst_s = 1'b1;
        step();
        checks += 4;
        if (vs.pix_x !== 10'd0) begin errors++; $display("FAIL mid_rst_x got %0d exp 0", vs.pix_x); end
        if (vs.pix_y !== 10'd0) begin errors++; $display("FAIL mid_rst_y got %0d exp 0", vs.pix_y); end
        if (vs.vsync !== 1'b1) begin errors++; $display("FAIL mid_rst_vsync got %b exp 1", vs.vsync); end
        if (vs.frame_start !== 1'b0) begin errors++; $display("FAIL mid_rst_frame_start got %b exp 0", vs.frame_start); end
        rst_s = 1'b0;
        step();
        checks += 2;
        if (vs.pix_x !== 10'd1) begin errors++; $display("FAIL mid_restart_x got %0d exp 1", vs.pix_x); end
        if (vs.frame_start !== 1'b0) begin errors++; $display("FAIL mid_restart_frame_start got %b exp 0", vs.frame_start); end
    endtask

    task automatic test_reset_priority();
        rst_s = 1'b1; vs.pix_en = 1'b1;
        step();
        rst_s = 1'b0;
        repeat (149) step();
        checks += 2;
        if (vs.pix_x !== 10'd14) begin errors++; $display("FAIL prio_pre_x got %0d exp 14", vs.pix_x); end
        if (vs.pix_y !== 10'd9) begin errors++; $display("FAIL prio_pre_y got %0d exp 9", vs.pix_y); end
        rst_s = 1'b1;
        step();
        checks += 2;
        if (vs.frame_start !== 1'b0) begin errors++; $display("FAIL prio_frame_start got %b exp 0", vs.frame_start); end
        if (vs.pix_x !== 10'd0) begin errors++; $display("FAIL prio_x got %0d exp 0", vs.pix_x); end
        rst_s = 1'b0;
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int fs_cnt;
        logic [7:0] cnt_first, cnt_last;
        fs_cnt = 0; cnt_first = 8'hff; cnt_last = 8'hff;
        rst_s = 1'b1; vs.pix_en = 1'b1;
        step();
        checks += 1;
        if (vs.frame_cnt !== 8'd0) begin errors++; $display("FAIL fcnt_reset got %0d exp 0", vs.frame_cnt); end
        rst_s = 1'b0;
        for (int k = 1; k <= 257 * 150 + 1; k++) begin
            step();
            if (vs.frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_cnt == 1) cnt_first = vs.frame_cnt;
                cnt_last = vs.frame_cnt;
            end
        end
        checks += 4;
        if (fs_cnt != 257) begin errors++; $display("FAIL fcnt_pulses got %0d exp 257", fs_cnt); end
        if (cnt_first !== 8'd1) begin errors++; $display("FAIL fcnt_first got %0d exp 1", cnt_first); end
        if (cnt_last !== 8'd1) begin errors++; $display("FAIL fcnt_wrap got %0d exp 1", cnt_last); end
        if (vs.frame_cnt !== 8'd1) begin errors++; $display("FAIL fcnt_hold got %0d exp 1", vs.frame_cnt); end
    endtask
`endif

    initial begin
        vd.pix_en = 1'b1;
        vs.pix_en = 1'b1;
        test_reset();
        test_hsync();
        test_hold();
        test_frame();
        test_divide();
        test_mid_reset();
        test_reset_priority();
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
